conv_mac_serial: RTL
====================

Name: conv_mac_serial

Overview:
- Parametrised serial convolution MAC: computes one output pixel per job.
- Accepts KERNEL_W*KERNEL_H*CHANNELS (pixel, weight) pairs over a valid/ready stream and accumulates their signed products onto a latched bias.
- Output path: arithmetic right-shift requantisation, optional ReLU, saturation to OUT_W; result is held under a valid/ready handshake.
- Sits between the window/line-buffer feeder and the feature-map writer.

Parameters:
- DATA_W, 8, signed pixel width
- WEIGHT_W, 8, signed weight width
- BIAS_W, 16, signed bias width (BIAS_W <= ACC_W)
- ACC_W, 24, accumulator width (ACC_W >= DATA_W+WEIGHT_W)
- OUT_W, 8, signed result width
- KERNEL_W, 3, kernel width
- KERNEL_H, 3, kernel height
- CHANNELS, 1, input channels per job
- SHIFT, 0, arithmetic right shift applied before activation
- RELU_EN, 1, 1 = clamp negatives to 0

Ports:
- clk_en  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- conv_en  in  1  job start; sampled only in IDLE
- bias_in  in  BIAS_W  signed bias; latched when conv_en is accepted
- in_valid  in  1  pixel/weight pair valid
- in_ready  out  1  block accepts a pair
- img_in  in  DATA_W  signed pixel
- weight_in  in  WEIGHT_W  signed weight
- result  out  OUT_W  signed output pixel
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- sat  out  1  result was saturated; valid with result_valid
- busy  out  1  high in every state except IDLE

Behaviour:
- Job length is N = KERNEL_W*KERNEL_H*CHANNELS, with N >= 1. The beat counter is wide enough to hold N.
- Reset (rst high at a clock edge):
  - State goes to IDLE.
  - acc, count, result, sat, result_valid, in_ready and busy all go to 0.
  - A reset mid-job discards the job entirely; nothing carries over.
- All outputs are registered.
- FSM states: IDLE, ACCUM, POST, OUT.
- IDLE:
  - in_ready = 0.
  - When conv_en = 1: acc <= sign-extended bias_in, count <= 0, go to ACCUM.
- ACCUM:
  - in_ready = 1.
  - A beat is accepted when in_valid && in_ready. On a beat: acc <= acc + sign-extended (img_in*weight_in); count <= count+1.
  - The full DATA_W+WEIGHT_W signed product is used.
  - acc wraps modulo 2^ACC_W; there is no accumulator saturation.
  - On the beat where count == N-1: go to POST, and in_ready drops the next cycle.
  - Cycles with in_valid = 0 are stalls; acc and count hold.
- POST (exactly one cycle):
  - v = acc >>> SHIFT (arithmetic shift).
  - If RELU_EN and v < 0, then v = 0.
  - Clamp v to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - result <= clamped v; sat <= 1 if clamping occurred, else 0.
  - result_valid <= 1; go to OUT.
- OUT:
  - result, sat and result_valid hold stable until result_ready = 1.
  - On the handshake edge: result_valid <= 0, go to IDLE. result and sat keep their values.
  - in_ready = 0 throughout OUT.
- conv_en is ignored in ACCUM, POST and OUT, including on the OUT handshake cycle. The next job needs conv_en while in IDLE.
- Latency, with no stalls:
  - conv_en sampled at edge E0.
  - Beats accepted on edges E1..EN.
  - result_valid is high from the cycle after edge E(N+1).
  - Throughput: N+3 cycles per job when result_ready is held high.
- in_valid while in IDLE, POST or OUT is not consumed; the source must hold the data.

Test Plan:
- Defaults. bias 0; pixels 1..9, weights all 1, back-to-back; result_ready = 1 → result = 45, sat = 0. result_valid asserted after edge E10 (N+1 = 10 edges after conv_en). busy high from E1 until the handshake.
- Negative sum. Pixels all 10, weights all -1, bias 5 → acc = -85. With RELU_EN = 1: result = 0, sat = 0. With RELU_EN = 0: result = -85, sat = 0.
- Saturation, RELU_EN = 0:
  - Pixels 127, weights 127 → acc = 145161 → result = 127, sat = 1.
  - Pixels -128, weights 127 → acc = -146304 → result = -128, sat = 1.
- Backpressure:
  - in_valid pattern 1,0,0,1,... → acc and count freeze on stall cycles; the result equals the no-stall run.
  - result_ready low for 5 cycles in OUT → result stable; in_ready = 0; a conv_en pulse during OUT is ignored (busy stays high, no new job).
- Reset mid-job: rst high after 4 accepted beats → next cycle all outputs 0 and state IDLE. A fresh job of pixels 2, weights 3, bias 1 → result 55, with no residue from the aborted job.
- Generalised config, CHANNELS = 2, SHIFT = 2, RELU_EN = 1: 18 beats of pixel 3, weight 2, bias 0 → acc = 108 → result = 27.

Source files
------------

// File: rtl/conv_mac_serial.sv
// Serial convolution MAC: accumulates N = KERNEL_W*KERNEL_H*CHANNELS signed
// pixel*weight products onto a latched bias, then requantises to one output pixel.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for conv_en; bias latched on start
// ACCUM | accepting pixel/weight beats until N have been summed
// POST  | one cycle: shift, optional ReLU, saturate, register result
// OUT   | result held until result_ready handshake
module conv_mac_serial #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int BIAS_W   = 16,
    parameter int ACC_W    = 24,
    parameter int OUT_W    = 8,
    parameter int KERNEL_W = 3,
    parameter int KERNEL_H = 3,
    parameter int CHANNELS = 1,
    parameter int SHIFT    = 0,
    parameter int RELU_EN  = 1
) (
    input  logic                       clk_en,
    input  logic                       rst,
    input  logic                       conv_en,
    input  logic signed [BIAS_W-1:0]   bias_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   img_in,
    input  logic signed [WEIGHT_W-1:0] weight_in,
    output logic signed [OUT_W-1:0]    result,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic                       sat,
    output logic                       busy
);

    localparam int N      = KERNEL_W * KERNEL_H * CHANNELS;
    localparam int CNT_W  = $clog2(N + 1);
    localparam int PROD_W = DATA_W + WEIGHT_W;

    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, POST, OUT} state_t;

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         count;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [ACC_W-1:0]  activ;
    logic signed [OUT_W-1:0]  clamped;
    logic                     clamp_hit;

    // Casts keep the operands signed so the full-width product is sign-correct.
    assign prod     = PROD_W'(img_in) * PROD_W'(weight_in);
    assign prod_ext = ACC_W'(prod);
    assign bias_ext = ACC_W'(bias_in);
    assign shifted  = acc >>> SHIFT;

    always_comb begin
        activ     = shifted;
        clamped   = shifted[OUT_W-1:0];
        clamp_hit = 1'b0;
        if (RELU_EN != 0 && shifted[ACC_W-1]) begin
            activ = '0;
        end
        clamped = activ[OUT_W-1:0];
        if (activ > OUT_MAX) begin
            clamped   = OUT_MAX[OUT_W-1:0];
            clamp_hit = 1'b1;
        end else if (activ < OUT_MIN) begin
            clamped   = OUT_MIN[OUT_W-1:0];
            clamp_hit = 1'b1;
        end
    end

    always_ff @(posedge clk_en) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            count        <= '0;
            result       <= '0;
            sat          <= 1'b0;
            result_valid <= 1'b0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (conv_en) begin
                        acc      <= bias_ext;
                        count    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc   <= acc + prod_ext;
                        count <= count + CNT_W'(1);
                        if (count == CNT_W'(N - 1)) begin
                            in_ready <= 1'b0;
                            state    <= POST;
                        end
                    end
                end
                POST: begin
                    result       <= clamped;
                    sat          <= clamp_hit;
                    result_valid <= 1'b1;
                    state        <= OUT;
                end
                OUT: begin
                    // conv_en is deliberately ignored here, even on the handshake cycle.
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
